// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } mem_owner_e;

    localparam int MEM_BE_W = 4;

endpackage

// File: rtl/mem_resp_tracker.sv
// Owner-tag delay line: each slot is the requester that owns the SRAM read
// data arriving RD_LATENCY cycles after the grant.
module mem_resp_tracker
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  mem_owner_e push,
    output mem_owner_e head
);

    mem_owner_e stage [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= push;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head = stage[RD_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and the data stage,
// with starvation relief for fetch and in-order read data steering.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [MEM_BE_W-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [MEM_BE_W-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                if_stall,
    output logic                dm_stall
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;
    logic             contested;
    mem_owner_e       push;
    mem_owner_e       head;

    // A limit of zero disables the relief path entirely.
    assign force_if  = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
    assign contested = if_req & dm_req;

    assign if_gnt   = ~rst & if_req & (~dm_req | force_if);
    assign dm_gnt   = ~rst & dm_req & ~(if_req & force_if);
    assign if_stall = if_req & ~if_gnt;
    assign dm_stall = dm_req & ~dm_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (dm_gnt && contested && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        push      = OWN_NONE;
        if (if_gnt) begin
            mem_addr = if_addr;
            push     = OWN_IF;
        end else if (dm_gnt) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            push      = dm_we ? OWN_NONE : OWN_DM;
        end
    end

    mem_resp_tracker #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tracker (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .head (head)
    );

    // A response landing while reset is held belongs to a dropped read.
    assign if_rvalid = ~rst & (head == OWN_IF);
    assign dm_rvalid = ~rst & (head == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule
